alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered results and flags.
// MUL (shift-add, WIDTH cycles) and SHL by n>0 (one bit per cycle) run
// behind a start/busy/done handshake; all other ops finish at accept.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_out,
    output logic [WIDTH-1:0] ALU_hi,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    localparam int CNT_W = SHW + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_XOR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_nx;
    logic               is_mul;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   sh;

    logic               accept, multi, last;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   sh_nx;

    assign busy = (state == RUN);

    // Handshake decode and one multi-cycle step (shift-add / shift-left)
    always_comb begin
        shamt    = Data_B[SHW-1:0];
        accept   = (state == IDLE) && start;
        multi    = accept && ((op_t'(op_sel) == OP_MUL) ||
                              ((op_t'(op_sel) == OP_SHL) && (shamt != '0)));
        last     = (state == RUN) && (cnt == CNT_W'(1));
        // Multiplier sits in the low half of prod and is consumed LSB first
        step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                   (prod[0] ? {1'b0, mcand} : '0);
        prod_nx  = {step_sum, prod[WIDTH-1:1]};
        sh_nx    = {sh[WIDTH-2:0], 1'b0};
    end

    // Single-cycle result and flags computed straight from the input ports
    always_comb begin
        wide  = '0;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (op_t'(op_sel))
            OP_ADD: begin
                wide  = {1'b0, Data_A} + {1'b0, Data_B};
                res   = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = (Data_A[WIDTH-1] == Data_B[WIDTH-1]) &&
                        (res[WIDTH-1] != Data_A[WIDTH-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, Data_A} - {1'b0, Data_B};
                res   = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = (Data_A[WIDTH-1] != Data_B[WIDTH-1]) &&
                        (res[WIDTH-1] != Data_A[WIDTH-1]);
            end
            OP_INC: begin
                wide  = {1'b0, Data_A} + (WIDTH+1)'(1);
                res   = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
                res_v = !Data_A[WIDTH-1] && res[WIDTH-1];
            end
            OP_XOR: res = Data_A ^ Data_B;
            OP_AND: res = Data_A & Data_B;
            OP_OR:  res = Data_A | Data_B;
            // Only reached as a single-cycle op when the shift amount is 0
            OP_SHL: res = Data_A;
            OP_MUL: res = '0;
            default: res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (multi) state_nx = RUN;
            RUN:  if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            is_mul   <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            sh       <= '0;
            ALU_out  <= '0;
            ALU_hi   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (multi) begin
                    is_mul <= (op_t'(op_sel) == OP_MUL);
                    mcand  <= Data_A;
                    prod   <= {{WIDTH{1'b0}}, Data_B};
                    sh     <= Data_A;
                    cnt    <= (op_t'(op_sel) == OP_MUL) ? CNT_W'(WIDTH)
                                                        : {1'b0, shamt};
                end else begin
                    done     <= 1'b1;
                    ALU_out  <= res;
                    ALU_hi   <= '0;
                    Zero     <= (res == '0);
                    Carry    <= res_c;
                    Negative <= res[WIDTH-1];
                    Overflow <= res_v;
                end
            end else if (state == RUN) begin
                cnt  <= cnt - CNT_W'(1);
                prod <= prod_nx;
                sh   <= sh_nx;
                // Final step: publish the just-computed value, not the stale register
                if (last) begin
                    done     <= 1'b1;
                    Overflow <= 1'b0;
                    if (is_mul) begin
                        ALU_out  <= prod_nx[WIDTH-1:0];
                        ALU_hi   <= prod_nx[2*WIDTH-1:WIDTH];
                        Zero     <= (prod_nx == '0);
                        Carry    <= |prod_nx[2*WIDTH-1:WIDTH];
                        Negative <= prod_nx[WIDTH-1];
                    end else begin
                        ALU_out  <= sh_nx;
                        ALU_hi   <= '0;
                        Zero     <= (sh_nx == '0);
                        Carry    <= sh[WIDTH-1];
                        Negative <= sh_nx[WIDTH-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int W  = 16;
    localparam int SW = $clog2(W);
    localparam int VW = 2*W + 4;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op_sel;
    logic [W-1:0] Data_A, Data_B;
    logic         busy, done;
    logic [W-1:0] ALU_out, ALU_hi;
    logic         Zero, Carry, Negative, Overflow;
    logic [VW-1:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
        .Data_A(Data_A), .Data_B(Data_B), .busy(busy), .done(done),
        .ALU_out(ALU_out), .ALU_hi(ALU_hi), .Zero(Zero), .Carry(Carry),
        .Negative(Negative), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    assign obs = {ALU_hi, ALU_out, Zero, Carry, Negative, Overflow};

    // Reference: {hi, lo, Z, C, N, V} and extra edges after accept until done
    function automatic logic [VW-1:0] model(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            output int lat);
        logic [2*W-1:0] p;
        logic [W-1:0]   lo, hi;
        logic           z, c, v;
        longint         sa, sb, s, mx, mn;
        int             n;
        sa = $signed(a);
        sb = $signed(b);
        mx = (longint'(1) << (W-1)) - 1;
        mn = -mx - 1;
        p = '0; lo = '0; hi = '0; c = 1'b0; v = 1'b0; lat = 0; s = 0;
        n = int'(b[SW-1:0]);
        case (op)
            3'd0: begin
                p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                lo = p[W-1:0]; c = p[W];
                s = sa + sb; v = (s > mx) || (s < mn);
            end
            3'd1: begin
                lo = a - b; c = (a < b);
                s = sa - sb; v = (s > mx) || (s < mn);
            end
            3'd2: begin
                p = {{W{1'b0}}, a} + 1;
                lo = p[W-1:0]; c = p[W];
                s = sa + 1; v = (s > mx);
            end
            3'd3: lo = a ^ b;
            3'd4: lo = a & b;
            3'd5: lo = a | b;
            3'd6: begin
                p = {{W{1'b0}}, a} << n;
                lo = p[W-1:0];
                c = (n == 0) ? 1'b0 : p[W];
                lat = n;
            end
            default: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                lo = p[W-1:0]; hi = p[2*W-1:W];
                c = (hi != '0);
                lat = W;
            end
        endcase
        z = (op == 3'd7) ? (p == '0) : (lo == '0);
        return {hi, lo, z, c, lo[W-1], v};
    endfunction

    // Issue one op; returns extra edges until done (-1 on timeout) and
    // whether busy was high throughout the run and low at done
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke,
                         output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op_sel = op; Data_A = a; Data_B = b;
        @(posedge clk); #1;
        start = 1'b0;
        op_sel = 3'($urandom); Data_A = W'($urandom); Data_B = W'($urandom);
        lat = 0;
        while (!done && lat <= W + 3) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && lat == 3) begin
                start = 1'b1; op_sel = 3'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (!done) lat = -1;
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_sel = '0; Data_A = '0; Data_B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, obs} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b outs=%h, need all 0", busy, done, obs);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add_sub();
        int lat; bit bok;
        logic [VW-1:0] exp;
        issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, lat, bok);
        exp = {16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp || lat != 0 || !bok) begin
            n_fail++;
            $display("FAIL add_ovf: got %h lat=%0d busy_ok=%0d, need %h lat=0", obs, lat, bok, exp);
        end
        issue(3'd1, 16'h0005, 16'h0005, 1'b0, lat, bok);
        exp = {16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp || lat != 0) begin
            n_fail++;
            $display("FAIL sub_zero: got %h lat=%0d, need %h lat=0", obs, lat, exp);
        end
        issue(3'd1, 16'h0003, 16'h0005, 1'b0, lat, bok);
        exp = {16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp || lat != 0) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h lat=%0d, need %h lat=0", obs, lat, exp);
        end
    endtask

    task automatic test_mul();
        int lat; bit bok;
        logic [VW-1:0] exp;
        issue(3'd7, 16'hFFFF, 16'hFFFF, 1'b1, lat, bok);
        exp = {16'hFFFE, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp || lat != W || !bok) begin
            n_fail++;
            $display("FAIL mul_max: got %h lat=%0d busy_ok=%0d, need %h lat=%0d", obs, lat, bok, exp, W);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || obs !== exp) begin
            n_fail++;
            $display("FAIL mul_hold: got done=%b busy=%b outs=%h, need done=0 busy=0 outs=%h", done, busy, obs, exp);
        end
    endtask

    task automatic test_shl();
        int lat; bit bok;
        logic [VW-1:0] exp;
        issue(3'd6, 16'h8001, 16'h0004, 1'b0, lat, bok);
        exp = {16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp || lat != 4 || !bok) begin
            n_fail++;
            $display("FAIL shl_4: got %h lat=%0d busy_ok=%0d, need %h lat=4", obs, lat, bok, exp);
        end
        issue(3'd6, 16'h8001, 16'h0000, 1'b0, lat, bok);
        exp = {16'h0000, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp || lat != 0) begin
            n_fail++;
            $display("FAIL shl_0: got %h lat=%0d, need %h lat=0", obs, lat, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        logic [VW-1:0] exp;
        logic [W-1:0] a, b;
        @(negedge clk);
        start = 1'b1; op_sel = 3'd2; Data_A = 16'hFFFF; Data_B = 16'h1234;
        @(posedge clk); #1;
        exp = {16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (done !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_inc: got done=%b outs=%h, need done=1 outs=%h", done, obs, exp);
        end
        op_sel = 3'd3; Data_A = 16'h00FF; Data_B = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        exp = {16'h0000, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (done !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_xor: got done=%b outs=%h, need done=1 outs=%h", done, obs, exp);
        end
        // New request presented in the same cycle a MUL reports done
        issue(3'd7, W'($urandom), W'($urandom), 1'b0, lat, bok);
        a = W'($urandom); b = W'($urandom);
        start = 1'b1; op_sel = 3'd0; Data_A = a; Data_B = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp = model(3'd0, a, b, lat);
        n_checks++;
        if (done !== 1'b1 || obs !== exp) begin
            n_fail++;
            $display("FAIL start_at_done: got done=%b outs=%h, need done=1 outs=%h", done, obs, exp);
        end
    endtask

    task automatic test_random();
        int lat, elat; bit bok;
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic [VW-1:0] exp;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a = W'($urandom); b = W'($urandom);
            if (i % 8 == 0) a = {1'b0, {(W-1){1'b1}}};
            exp = model(op, a, b, elat);
            issue(op, a, b, 1'b0, lat, bok);
            n_checks++;
            if (obs !== exp || lat != elat || !bok) begin
                n_fail++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h lat=%0d busy_ok=%0d, need %h lat=%0d",
                         i, op, a, b, obs, lat, bok, exp, elat);
            end
        end
    endtask

    task automatic test_mul_abort();
        int lat, pulses; bit bok;
        logic [VW-1:0] exp;
        @(negedge clk);
        start = 1'b1; op_sel = 3'd7; Data_A = 16'h1234; Data_B = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, obs} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b done=%b outs=%h, need all 0", busy, done, obs);
        end
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_silent: got %0d cycles with done/busy, need 0", pulses);
        end
        issue(3'd0, 16'd2, 16'd3, 1'b0, lat, bok);
        exp = {16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp || lat != 0) begin
            n_fail++;
            $display("FAIL abort_recover: got %h lat=%0d, need %h lat=0", obs, lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_shl();
        test_back_to_back();
        test_random();
        test_mul_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
